// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV control unit:
// FSM state, error codes, opcode constants and instruction field positions.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH_ADDR,
        S_FETCH_WAIT,
        S_DECODE,
        S_RS1,
        S_RS2,
        S_IMM,
        S_EXEC,
        S_TRAP
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ILLEGAL = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_t;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] F7_ADD   = 7'h00;
    localparam logic [6:0] F7_SUB   = 7'h20;
    localparam logic [2:0] F3_ADD   = 3'b000;

    localparam int OPC_LSB = 0;
    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int F7_LSB  = 25;
    localparam int RF_AW   = 2;

    // One bundle for every datapath control line driven by the FSM.
    typedef struct packed {
        logic             imem_req;
        logic             sel_alu_func;
        logic             ir_en;
        logic             a_en;
        logic             b_en;
        logic             pc_en;
        logic             immgen_bus_en;
        logic             alu_bus_en;
        logic             pc_bus_en;
        logic             rf_bus_en;
        logic             rf_wen;
        logic             rf_ren;
        logic [RF_AW-1:0] rf_addr_sel;
        logic             retire;
    } ctrl_t;

endpackage

// File: rtl/rv_instr_decode.sv
// Combinational instruction classifier: recognises ADD, SUB and ADDI and
// extracts the truncated register addresses for the 4-entry register file.
module rv_instr_decode
    import ctrl_pkg::*;
(
    input  logic [31:0]      instr,
    output logic             is_rtype,
    output logic             is_itype,
    output logic             is_sub,
    output logic             legal,
    output logic [RF_AW-1:0] rs1,
    output logic [RF_AW-1:0] rs2,
    output logic [RF_AW-1:0] rd
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_bits;

    assign opcode = instr[OPC_LSB +: 7];
    assign funct3 = instr[F3_LSB +: 3];
    assign funct7 = instr[F7_LSB +: 7];

    assign is_rtype = (opcode == OP_RTYPE) && (funct3 == F3_ADD) &&
                      ((funct7 == F7_ADD) || (funct7 == F7_SUB));
    assign is_itype = (opcode == OP_ITYPE) && (funct3 == F3_ADD);
    assign is_sub   = is_rtype & instr[30];
    assign legal    = is_rtype | is_itype;

    // Upper address bits are dropped: the register file has only 4 entries.
    assign rs1 = instr[RS1_LSB +: RF_AW];
    assign rs2 = instr[RS2_LSB +: RF_AW];
    assign rd  = instr[RD_LSB  +: RF_AW];

    assign unused_bits = ^{instr[RD_LSB+RF_AW +: 3], instr[RS1_LSB+RF_AW +: 3],
                           instr[RS2_LSB+RF_AW +: 3]};

endmodule

// File: rtl/rv_ctrl_unit.sv
// Multi-cycle control unit for ADD/SUB/ADDI: fetch handshake with timeout,
// decode, operand load, execute/writeback, and a sticky trap state.
module rv_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int FETCH_TIMEOUT = 16,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [31:0]      instr,
    input  logic             alu_carry,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             sel_alu_func,
    output logic             ir_en,
    output logic             a_en,
    output logic             b_en,
    output logic             pc_en,
    output logic             immgen_bus_en,
    output logic             alu_bus_en,
    output logic             pc_bus_en,
    output logic             rf_bus_en,
    output logic             rf_wen,
    output logic             rf_ren,
    output logic [1:0]       rf_addr_sel,
    output logic             carry_flag,
    output logic             retire,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [1:0]       err_code
);

    localparam int              TO_W    = (FETCH_TIMEOUT > 2) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam bit              TO_EN   = (FETCH_TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(FETCH_TIMEOUT - 1);

    state_t            state;
    err_t              err_q;
    logic [TO_W-1:0]   wait_cnt;
    ctrl_t             ctl;

    logic              is_rtype, is_itype, is_sub, legal;
    logic [RF_AW-1:0]  rs1, rs2, rd;

    rv_instr_decode u_dec (
        .instr    (instr),
        .is_rtype (is_rtype),
        .is_itype (is_itype),
        .is_sub   (is_sub),
        .legal    (legal),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            err_q       <= ERR_NONE;
            wait_cnt    <= '0;
            carry_flag  <= 1'b0;
            retired_cnt <= '0;
        end else begin
            case (state)
                S_IDLE:       if (run) state <= S_FETCH_ADDR;
                S_FETCH_ADDR: begin
                    wait_cnt <= '0;
                    state    <= S_FETCH_WAIT;
                end
                S_FETCH_WAIT: begin
                    // An ack in the expiring cycle still completes the fetch.
                    if (imem_ack) begin
                        state <= S_DECODE;
                    end else if (TO_EN && (wait_cnt == TO_LAST)) begin
                        state <= S_TRAP;
                        err_q <= ERR_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end
                S_DECODE: begin
                    if (legal) begin
                        state <= S_RS1;
                    end else begin
                        state <= S_TRAP;
                        err_q <= ERR_ILLEGAL;
                    end
                end
                S_RS1:        state <= is_itype ? S_IMM : S_RS2;
                S_RS2, S_IMM: state <= S_EXEC;
                S_EXEC: begin
                    carry_flag  <= alu_carry;
                    retired_cnt <= retired_cnt + CNT_W'(1);
                    state       <= run ? S_FETCH_ADDR : S_IDLE;
                end
                S_TRAP:       state <= S_TRAP;
                default:      state <= S_IDLE;
            endcase
        end
    end

    // Moore decode of the control lines; ir_en alone follows the ack so the
    // word is captured in the cycle memory drives it.
    always_comb begin
        ctl = '0;
        case (state)
            S_FETCH_ADDR: begin
                ctl.imem_req  = 1'b1;
                ctl.pc_bus_en = 1'b1;
            end
            S_FETCH_WAIT: begin
                ctl.imem_req = 1'b1;
                ctl.ir_en    = imem_ack;
            end
            S_RS1: begin
                ctl.rf_ren      = 1'b1;
                ctl.rf_bus_en   = 1'b1;
                ctl.rf_addr_sel = rs1;
                ctl.a_en        = 1'b1;
            end
            S_RS2: begin
                ctl.rf_ren      = 1'b1;
                ctl.rf_bus_en   = 1'b1;
                ctl.rf_addr_sel = rs2;
                ctl.b_en        = 1'b1;
            end
            S_IMM: begin
                ctl.immgen_bus_en = 1'b1;
                ctl.b_en          = 1'b1;
            end
            S_EXEC: begin
                ctl.alu_bus_en   = 1'b1;
                ctl.rf_wen       = 1'b1;
                ctl.rf_addr_sel  = rd;
                ctl.retire       = 1'b1;
                ctl.sel_alu_func = is_sub;
            end
            default: ctl = '0;
        endcase
    end

    assign imem_req      = ctl.imem_req;
    assign sel_alu_func  = ctl.sel_alu_func;
    assign ir_en         = ctl.ir_en;
    assign a_en          = ctl.a_en;
    assign b_en          = ctl.b_en;
    assign pc_en         = ctl.pc_en;
    assign immgen_bus_en = ctl.immgen_bus_en;
    assign alu_bus_en    = ctl.alu_bus_en;
    assign pc_bus_en     = ctl.pc_bus_en;
    assign rf_bus_en     = ctl.rf_bus_en;
    assign rf_wen        = ctl.rf_wen;
    assign rf_ren        = ctl.rf_ren;
    assign rf_addr_sel   = ctl.rf_addr_sel;
    assign retire        = ctl.retire;
    assign err_code      = err_q;

endmodule

// File: tb/tb_rv_ctrl_unit.sv
// Self-checking bench for rv_ctrl_unit: directed scenarios plus randomized
// instruction streams checked against a phase-sequence reference model.
module tb_rv_ctrl_unit;

    localparam int TO = 4;
    localparam int CW = 4;

    logic          clk = 1'b0, rst_n = 1'b0, run = 1'b0, alu_carry = 1'b0, imem_ack = 1'b0;
    logic [31:0]   instr = '0;
    logic          imem_req, sel_alu_func, ir_en, a_en, b_en, pc_en;
    logic          immgen_bus_en, alu_bus_en, pc_bus_en, rf_bus_en, rf_wen, rf_ren;
    logic [1:0]    rf_addr_sel, err_code;
    logic          carry_flag, retire;
    logic [CW-1:0] retired_cnt;

    rv_ctrl_unit #(.FETCH_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .instr(instr), .alu_carry(alu_carry),
        .imem_req(imem_req), .imem_ack(imem_ack), .sel_alu_func(sel_alu_func),
        .ir_en(ir_en), .a_en(a_en), .b_en(b_en), .pc_en(pc_en),
        .immgen_bus_en(immgen_bus_en), .alu_bus_en(alu_bus_en), .pc_bus_en(pc_bus_en),
        .rf_bus_en(rf_bus_en), .rf_wen(rf_wen), .rf_ren(rf_ren), .rf_addr_sel(rf_addr_sel),
        .carry_flag(carry_flag), .retire(retire), .retired_cnt(retired_cnt), .err_code(err_code)
    );

    always #5 clk = ~clk;

    logic [14:0] outv;
    logic [3:0]  buses;
    assign outv  = {imem_req, sel_alu_func, ir_en, a_en, b_en, pc_en, immgen_bus_en,
                    alu_bus_en, pc_bus_en, rf_bus_en, rf_wen, rf_ren, rf_addr_sel, retire};
    assign buses = {immgen_bus_en, alu_bus_en, pc_bus_en, rf_bus_en};

    int            errors = 0, checks = 0;
    logic [CW-1:0] exp_cnt = '0;
    logic          exp_carry = 1'b0;

    typedef enum {P_IDLE, P_FA, P_FW, P_DEC, P_RS1, P_RS2, P_IMM, P_EX, P_TRAP} ph_t;

    // 0 = illegal, 1 = ADD/SUB, 2 = ADDI
    function automatic int ref_kind(logic [31:0] ins);
        logic [6:0] op, f7;
        logic [2:0] f3;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        if (op == 7'b0110011 && f3 == 3'd0 && (f7 == 7'h00 || f7 == 7'h20)) return 1;
        if (op == 7'b0010011 && f3 == 3'd0) return 2;
        return 0;
    endfunction

    function automatic logic [14:0] exp_out(ph_t p, logic [31:0] ins, logic ack);
        logic req, sel, ir, a, b, imm, alu, pcb, rfb, wen, ren, ret;
        logic [1:0] addr;
        {req, sel, ir, a, b, imm, alu, pcb, rfb, wen, ren, ret} = '0;
        addr = 2'd0;
        case (p)
            P_FA:  begin req = 1; pcb = 1; end
            P_FW:  begin req = 1; ir = ack; end
            P_RS1: begin ren = 1; rfb = 1; a = 1; addr = ins[16:15]; end
            P_RS2: begin ren = 1; rfb = 1; b = 1; addr = ins[21:20]; end
            P_IMM: begin imm = 1; b = 1; end
            P_EX:  begin alu = 1; wen = 1; ret = 1; addr = ins[8:7];
                         sel = (ref_kind(ins) == 1) && ins[30]; end
            default: ;
        endcase
        return {req, sel, ir, a, b, 1'b0, imm, alu, pcb, rfb, wen, ren, addr, ret};
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        int sel;
        r = $urandom;
        sel = $urandom_range(0, 9);
        if (sel < 4)       return {(sel < 2) ? 7'h20 : 7'h00, r[24:15], 3'b000, r[11:7], 7'b0110011};
        else if (sel < 7)  return {r[31:15], 3'b000, r[11:7], 7'b0010011};
        else if (sel == 7) return {7'h01, r[24:15], 3'b000, r[11:7], 7'b0110011};
        else if (sel == 8) return {r[31:15], r[14:12] | 3'b001, r[11:7], 7'b0010011};
        else               return {r[31:7], 7'b1100011};
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; #1;
        checks++; if (outv !== '0) begin errors++; $display("FAIL rst_out: got %h want 0", outv); end
        checks++; if (err_code !== 2'd0 || retired_cnt !== '0 || carry_flag !== 1'b0) begin
            errors++; $display("FAIL rst_regs: err=%0d cnt=%0d carry=%b want 0/0/0", err_code, retired_cnt, carry_flag); end
        step();
        rst_n = 1'b1; exp_cnt = '0; exp_carry = 1'b0;
    endtask

    // From IDLE: raise run; the next cycle is FETCH_ADDR.
    task automatic start();
        run = 1'b1; #1;
        checks++; if (outv !== '0) begin errors++; $display("FAIL idle_out: got %h want 0", outv); end
        step();
    endtask

    // Drives one instruction from FETCH_ADDR. ack_at = wait cycle of the ack (0 = never).
    task automatic do_instr(input logic [31:0] ins, input int ack_at, input logic carry,
                            input logic run_next, input bit jitter_run, output bit trapped);
        int kind, n;
        ph_t ops[2];
        kind = ref_kind(ins);
        trapped = 1'b0;
        imem_ack = 1'b0; #1;
        checks++; if (outv !== exp_out(P_FA, ins, 1'b0)) begin errors++; $display("FAIL fa_out: got %h want %h", outv, exp_out(P_FA, ins, 1'b0)); end
        step();
        n = (ack_at == 0) ? TO : ack_at;
        for (int k = 1; k <= n; k++) begin
            imem_ack = (k == ack_at);
            if (k == ack_at) instr = ins;
            if (jitter_run) run = 1'(($urandom) & 1);
            #1;
            checks++; if (outv !== exp_out(P_FW, ins, imem_ack)) begin errors++; $display("FAIL fw_out: got %h want %h", outv, exp_out(P_FW, ins, imem_ack)); end
            step();
        end
        imem_ack = 1'b0;
        if (ack_at == 0) begin
            #1; trapped = 1'b1;
            checks++; if (outv !== '0 || err_code !== 2'd2) begin errors++; $display("FAIL timeout_trap: out=%h err=%0d want 0/2", outv, err_code); end
            return;
        end
        #1;
        checks++; if (outv !== '0) begin errors++; $display("FAIL dec_out: got %h want 0", outv); end
        step();
        if (kind == 0) begin
            #1; trapped = 1'b1;
            checks++; if (outv !== '0 || err_code !== 2'd1) begin errors++; $display("FAIL illegal_trap: out=%h err=%0d want 0/1", outv, err_code); end
            return;
        end
        ops[0] = P_RS1;
        ops[1] = (kind == 1) ? P_RS2 : P_IMM;
        for (int j = 0; j < 2; j++) begin
            if (jitter_run) run = 1'(($urandom) & 1);
            #1;
            checks++; if (outv !== exp_out(ops[j], ins, 1'b0) || $countones(buses) > 1) begin
                errors++; $display("FAIL operand_out: phase=%0d got %h want %h", j, outv, exp_out(ops[j], ins, 1'b0)); end
            step();
        end
        alu_carry = carry; run = run_next; #1;
        checks++; if (outv !== exp_out(P_EX, ins, 1'b0)) begin errors++; $display("FAIL exec_out: got %h want %h", outv, exp_out(P_EX, ins, 1'b0)); end
        step();
        exp_cnt = exp_cnt + 1'b1; exp_carry = carry;
        checks++; if (retired_cnt !== exp_cnt || carry_flag !== exp_carry || err_code !== 2'd0) begin
            errors++; $display("FAIL retire_state: cnt=%0d carry=%b err=%0d want %0d/%b/0", retired_cnt, carry_flag, err_code, exp_cnt, exp_carry); end
    endtask

    task automatic test_reset();
        do_reset();
        repeat (3) step();
        #1;
        checks++; if (outv !== '0 || retired_cnt !== '0) begin errors++; $display("FAIL idle_hold: out=%h cnt=%0d want 0/0", outv, retired_cnt); end
    endtask

    task automatic test_alu_ops();
        bit t;
        start(); do_instr(32'h002081B3, 1, 1'b0, 1'b0, 0, t);   // ADD x3,x1,x2
        start(); do_instr(32'h403100B3, 1, 1'b1, 1'b0, 0, t);   // SUB x1,x2,x3
        start(); do_instr(32'h00508113, 2, 1'b0, 1'b0, 0, t);   // ADDI x2,x1,5
        checks++; if (retired_cnt !== 4'd3 || carry_flag !== 1'b0) begin errors++; $display("FAIL alu_ops_cnt: cnt=%0d carry=%b want 3/0", retired_cnt, carry_flag); end
    endtask

    task automatic test_illegal();
        bit t;
        do_reset();
        start(); do_instr(32'h00000063, 1, 1'b0, 1'b0, 0, t);
        for (int i = 0; i < 6; i++) begin
            run = 1'(i & 1); imem_ack = 1'(($urandom) & 1); step();
            checks++; if (outv !== '0 || err_code !== 2'd1) begin errors++; $display("FAIL trap_sticky: out=%h err=%0d want 0/1", outv, err_code); end
        end
        do_reset();
    endtask

    task automatic test_timeout();
        bit t;
        start(); do_instr(32'h002081B3, 0, 1'b0, 1'b0, 0, t);
        do_reset();
        start(); do_instr(32'h002081B3, TO, 1'b1, 1'b0, 0, t);
        checks++; if (t !== 1'b0 || retired_cnt !== 4'd1) begin errors++; $display("FAIL ack_at_expiry: trapped=%b cnt=%0d want 0/1", t, retired_cnt); end
    endtask

    task automatic test_back_to_back();
        bit t;
        do_reset();
        start();
        do_instr(32'h002081B3, 1, 1'b1, 1'b1, 0, t);
        do_instr(32'h403100B3, 2, 1'b0, 1'b0, 1, t);
        step();
        checks++; if (outv !== '0 || retired_cnt !== 4'd2) begin errors++; $display("FAIL b2b_idle: out=%h cnt=%0d want 0/2", outv, retired_cnt); end
        start(); do_instr(32'h00508113, 3, 1'b1, 1'b0, 0, t);
    endtask

    task automatic test_reset_mid();
        bit t;
        do_reset();
        start();
        step();                                        // FETCH_WAIT
        instr = 32'h002081B3; imem_ack = 1'b1; step(); // DECODE
        imem_ack = 1'b0; step(); step();               // RS2
        rst_n = 1'b0; #1;
        checks++; if (outv !== '0 || retired_cnt !== '0) begin errors++; $display("FAIL mid_reset: out=%h cnt=%0d want 0/0", outv, retired_cnt); end
        run = 1'b0; step(); rst_n = 1'b1; exp_cnt = '0; exp_carry = 1'b0;
        step();
        checks++; if (outv !== '0 || retired_cnt !== '0) begin errors++; $display("FAIL mid_reset_idle: out=%h cnt=%0d want 0/0", outv, retired_cnt); end
        start(); do_instr(32'h00508113, 1, 1'b0, 1'b0, 0, t);
    endtask

    task automatic test_wrap();
        bit t;
        do_reset();
        start();
        for (int i = 0; i < 17; i++)
            do_instr({7'h00, 5'($urandom), 5'($urandom), 3'b000, 5'($urandom), 7'b0110011},
                     1, 1'(i & 1), (i != 16), 0, t);
        checks++; if (retired_cnt !== 4'd1) begin errors++; $display("FAIL cnt_wrap: got %0d want 1", retired_cnt); end
    endtask

    task automatic test_random();
        bit t;
        logic [31:0] ins;
        int ack;
        do_reset();
        start();
        for (int i = 0; i < 40; i++) begin
            ins = gen_instr();
            ack = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TO);
            do_instr(ins, ack, 1'(($urandom) & 1), 1'b1, 1, t);
            if (t) begin do_reset(); start(); end
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
